// File: rtl/startracker_pkg.sv
// ---------------------------------------------------------------------------
// startracker_pkg
// Shared constants and types for the histogram threshold controller.
//   HIST_BINS : number of histogram bins (one per pixel value)
//   BIN_W     : width of one histogram bin count
//   ACC_W     : width of the cumulative-count accumulator and the target
//   PIX_W     : pixel width, also the bin index width
//   state_e   : controller FSM states
// ---------------------------------------------------------------------------
package startracker_pkg;

  localparam int HIST_BINS = 256;
  localparam int BIN_W     = 16;
  localparam int ACC_W     = 24;
  localparam int PIX_W     = 8;
  localparam int CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WAIT_HIST,
    ST_SCAN,
    ST_RELEASE,
    ST_EMIT
  } state_e;

  // A zero target would make bin 0 win even when it is empty; treating it
  // as 1 makes the threshold the first populated bin instead.
  function automatic logic [ACC_W-1:0] norm_target(input logic [ACC_W-1:0] t);
    return (t == '0) ? ACC_W'(1) : t;
  endfunction

endpackage

// File: rtl/hist_cdf_scan.sv
// ---------------------------------------------------------------------------
// hist_cdf_scan
// Walks the histogram one bin per cycle, accumulating the cumulative count,
// and flags the first bin at which the cumulative count reaches the target.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_clear          : zero the index and accumulator (start of a scan)
//   i_scan_en        : scanning this cycle
//   i_hist_bins      : bin array, indexed by the internal bin index
//   i_target         : cumulative count that defines the threshold (>= 1)
//   o_done           : scan finishes this cycle (target hit or last bin)
//   o_hit            : cumulative count through the current bin >= target
//   o_idx            : bin currently being examined
// ---------------------------------------------------------------------------
module hist_cdf_scan
  import startracker_pkg::*;
(
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic                              i_clear,
  input  logic                              i_scan_en,
  input  logic [HIST_BINS-1:0][BIN_W-1:0]   i_hist_bins,
  input  logic [ACC_W-1:0]                  i_target,
  output logic                              o_done,
  output logic                              o_hit,
  output logic [PIX_W-1:0]                  o_idx
);

  logic [PIX_W-1:0] r_idx;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;
  logic             w_hit;
  logic             w_last;

  // 256 x 65535 < 2^24, so the sum never wraps.
  assign w_sum  = r_acc + ACC_W'(i_hist_bins[r_idx]);
  assign w_hit  = (w_sum >= i_target);
  assign w_last = (r_idx == PIX_W'(HIST_BINS - 1));

  assign o_done = i_scan_en & (w_hit | w_last);
  assign o_hit  = w_hit;
  assign o_idx  = r_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (i_scan_en && !o_done) begin
      r_idx <= r_idx + PIX_W'(1);
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/hist_threshold_ctrl.sv
// ---------------------------------------------------------------------------
// hist_threshold_ctrl
// Per-frame controller: forwards a pixel frame into an external histogram,
// waits for it, scans the cumulative distribution for the first bin reaching
// a target count, releases the histogram and presents the threshold.
// Ports:
//   i_clk, i_reset_n                       : clock, async active-low reset
//   i_pix_valid/data/last, o_pix_ready     : upstream pixel stream
//   o_hist_valid/data/last, i_hist_ready   : histogram write stream
//   i_hist_bins, i_hist_done, o_hist_ack   : histogram read / release
//   i_enable, i_target                     : run frames, threshold target
//   o_thr, o_thr_sat, o_thr_valid,
//   i_thr_ready                            : threshold result handshake
//   o_busy, o_frame_cnt                    : status
// ---------------------------------------------------------------------------
module hist_threshold_ctrl
  import startracker_pkg::*;
(
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic                              i_pix_valid,
  input  logic [PIX_W-1:0]                  i_pix_data,
  input  logic                              i_pix_last,
  output logic                              o_pix_ready,
  output logic                              o_hist_valid,
  output logic [PIX_W-1:0]                  o_hist_data,
  output logic                              o_hist_last,
  input  logic                              i_hist_ready,
  input  logic [HIST_BINS-1:0][BIN_W-1:0]   i_hist_bins,
  input  logic                              i_hist_done,
  output logic                              o_hist_ack,
  input  logic                              i_enable,
  input  logic [ACC_W-1:0]                  i_target,
  output logic [PIX_W-1:0]                  o_thr,
  output logic                              o_thr_sat,
  output logic                              o_thr_valid,
  input  logic                              i_thr_ready,
  output logic                              o_busy,
  output logic [CNT_W-1:0]                  o_frame_cnt
);

  state_e           r_state;
  state_e           w_next_state;
  logic [ACC_W-1:0] r_target;
  logic [PIX_W-1:0] r_thr;
  logic             r_thr_sat;
  logic [CNT_W-1:0] r_frame_cnt;

  logic             w_latch_target;
  logic             w_scan_clear;
  logic             w_scan_en;
  logic             w_frame_done;
  logic             w_scan_done;
  logic             w_scan_hit;
  logic [PIX_W-1:0] w_scan_idx;

  hist_cdf_scan u_scan (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_clear     (w_scan_clear),
    .i_scan_en   (w_scan_en),
    .i_hist_bins (i_hist_bins),
    .i_target    (r_target),
    .o_done      (w_scan_done),
    .o_hit       (w_scan_hit),
    .o_idx       (w_scan_idx)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal driven here gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state   = r_state;
    o_pix_ready    = 1'b0;
    o_hist_valid   = 1'b0;
    o_hist_data    = '0;
    o_hist_last    = 1'b0;
    o_hist_ack     = 1'b0;
    o_thr_valid    = 1'b0;
    w_latch_target = 1'b0;
    w_scan_clear   = 1'b0;
    w_scan_en      = 1'b0;
    w_frame_done   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_latch_target = 1'b1;
          w_next_state   = ST_FILL;
        end
      end

      // Pure pass-through; i_hist_ready also holds off pixels while the
      // histogram is still clearing after a release. i_enable is not looked
      // at here, so a started frame always completes.
      ST_FILL: begin
        o_hist_valid = i_pix_valid;
        o_hist_data  = i_pix_data;
        o_hist_last  = i_pix_last;
        o_pix_ready  = i_hist_ready;
        if (i_pix_valid && i_hist_ready && i_pix_last) begin
          w_next_state = ST_WAIT_HIST;
        end
      end

      // i_hist_done is only sampled here; a residual done after the ack
      // lands in EMIT/FILL and is ignored.
      ST_WAIT_HIST: begin
        if (i_hist_done) begin
          w_scan_clear = 1'b1;
          w_next_state = ST_SCAN;
        end
      end

      ST_SCAN: begin
        w_scan_en = 1'b1;
        if (w_scan_done) begin
          w_next_state = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        o_hist_ack   = 1'b1;
        w_next_state = ST_EMIT;
      end

      ST_EMIT: begin
        o_thr_valid = 1'b1;
        if (i_thr_ready) begin
          w_frame_done = 1'b1;
          if (i_enable) begin
            w_latch_target = 1'b1;
            w_next_state   = ST_FILL;
          end else begin
            w_next_state   = ST_IDLE;
          end
        end
      end

      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_target    <= '0;
      r_thr       <= '0;
      r_thr_sat   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_latch_target) begin
        r_target <= norm_target(i_target);
      end
      // Result registers only change at the end of a scan, so they hold
      // steady for the whole EMIT handshake.
      if (w_scan_en && w_scan_done) begin
        r_thr     <= w_scan_hit ? w_scan_idx : PIX_W'(HIST_BINS - 1);
        r_thr_sat <= ~w_scan_hit;
      end
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  assign o_thr       = r_thr;
  assign o_thr_sat   = r_thr_sat;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_hist_threshold_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hist_threshold_ctrl
// Directed bench for hist_threshold_ctrl. A behavioural histogram counts the
// written pixels, raises done, and clears on ack or reset. A frame-level
// model computes the threshold from the pixel list; a compare process checks
// the DUT against it every cycle, and each test pins hand-computed literals.
// ---------------------------------------------------------------------------
module tb_hist_threshold_ctrl;

  logic               i_clk       = 1'b0;
  logic               i_reset_n   = 1'b0;
  logic               i_pix_valid = 1'b0;
  logic [7:0]         i_pix_data  = '0;
  logic               i_pix_last  = 1'b0;
  logic               o_pix_ready;
  logic               o_hist_valid;
  logic [7:0]         o_hist_data;
  logic               o_hist_last;
  logic               i_hist_ready = 1'b1;
  logic [255:0][15:0] i_hist_bins  = '0;
  logic               i_hist_done  = 1'b0;
  logic               o_hist_ack;
  logic               i_enable     = 1'b0;
  logic [23:0]        i_target     = '0;
  logic [7:0]         o_thr;
  logic               o_thr_sat;
  logic               o_thr_valid;
  logic               i_thr_ready  = 1'b0;
  logic               o_busy;
  logic [15:0]        o_frame_cnt;

  hist_threshold_ctrl dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_pix_valid  (i_pix_valid),
    .i_pix_data   (i_pix_data),
    .i_pix_last   (i_pix_last),
    .o_pix_ready  (o_pix_ready),
    .o_hist_valid (o_hist_valid),
    .o_hist_data  (o_hist_data),
    .o_hist_last  (o_hist_last),
    .i_hist_ready (i_hist_ready),
    .i_hist_bins  (i_hist_bins),
    .i_hist_done  (i_hist_done),
    .o_hist_ack   (o_hist_ack),
    .i_enable     (i_enable),
    .i_target     (i_target),
    .o_thr        (o_thr),
    .o_thr_sat    (o_thr_sat),
    .o_thr_valid  (o_thr_valid),
    .i_thr_ready  (i_thr_ready),
    .o_busy       (o_busy),
    .o_frame_cnt  (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  int         n_checks = 0;
  int         n_err    = 0;
  int         exp_thr  = 0;
  bit         exp_sat  = 1'b0;
  int         exp_fc   = 0;
  int         ack_cnt  = 0;
  int         scan_cnt = 0;
  int         wr_cnt   = 0;
  int         frame_len_seen = 0;
  int         clr      = 0;
  int         cd       = 0;
  bit         resid    = 1'b0;
  bit         toggle_mode = 1'b0;
  logic       prev_ack = 1'b0;
  logic [7:0] frame_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Threshold from the frame contents: first bin whose cumulative count
  // reaches max(target,1); otherwise 255 and saturated.
  function automatic void model_thr(input int cnt[256], input int tgt,
                                    output int thr, output bit sat);
    int t;
    int cum;
    t   = (tgt == 0) ? 1 : tgt;
    cum = 0;
    thr = 255;
    sat = 1'b1;
    for (int b = 0; b < 256; b++) begin
      cum += cnt[b];
      if (cum >= t) begin
        thr = b;
        sat = 1'b0;
        return;
      end
    end
  endfunction

  // Behavioural histogram: inputs change on the falling edge, writes are
  // sampled 1 time unit later (what the next rising edge will see).
  always begin
    @(negedge i_clk);
    if (!i_reset_n) begin
      i_hist_bins  = '0;
      i_hist_done  = 1'b0;
      i_hist_ready = 1'b1;
      clr   = 0;
      cd    = 0;
      resid = 1'b0;
      wr_cnt = 0;
    end else begin
      if (o_hist_ack) begin
        ack_cnt++;
        i_hist_bins = '0;
        wr_cnt = 0;
        clr    = 3;
        resid  = 1'b1;         // keep done one extra cycle after the ack
      end else if (resid) begin
        i_hist_done = 1'b0;
        resid = 1'b0;
      end
      if (i_hist_done && !o_hist_ack) scan_cnt++;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          i_hist_done = 1'b1;
          scan_cnt = 0;
        end
      end
      if (clr > 0) begin
        i_hist_ready = 1'b0;
        clr--;
      end else if (toggle_mode) begin
        i_hist_ready = ~i_hist_ready;
      end else begin
        i_hist_ready = 1'b1;
      end
      #1;
      if (o_hist_valid && i_hist_ready) begin
        i_hist_bins[o_hist_data] = i_hist_bins[o_hist_data] + 16'd1;
        wr_cnt++;
        if (o_hist_last) begin
          cd = 2;
          frame_len_seen = wr_cnt;
        end
      end
    end
  end

  // Per-cycle compare against the model and the interface rules.
  always begin
    @(negedge i_clk);
    #2;
    if (i_reset_n) begin
      if (!o_busy)
        check("idle_outputs_zero", {28'd0, o_pix_ready, o_hist_valid, o_hist_ack, o_thr_valid}, 32'd0);
      if (o_pix_ready || o_hist_valid) begin
        check("fill_valid_pass", o_hist_valid, i_pix_valid);
        check("fill_ready_pass", o_pix_ready, i_hist_ready);
        if (o_hist_valid) begin
          check("fill_data_pass", o_hist_data, i_pix_data);
          check("fill_last_pass", o_hist_last, i_pix_last);
        end
      end
      if (o_hist_ack) check("ack_single_cycle", prev_ack, 1'b0);
      if (o_thr_valid) begin
        check("model_thr", o_thr, exp_thr);
        check("model_sat", o_thr_sat, exp_sat);
      end
      prev_ack = o_hist_ack;
    end else begin
      prev_ack = 1'b0;
    end
  end

  task automatic send_frame();
    int guard;
    for (int k = 0; k < frame_q.size(); k++) begin
      i_pix_valid = 1'b1;
      i_pix_data  = frame_q[k];
      i_pix_last  = (k == frame_q.size() - 1);
      guard = 0;
      #1;
      while (!o_pix_ready && guard < 200) begin
        @(negedge i_clk);
        #1;
        guard++;
      end
      if (guard >= 200) begin
        check("pix_accept_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge i_clk);
    end
    i_pix_valid = 1'b0;
    i_pix_last  = 1'b0;
    i_pix_data  = '0;
  endtask

  task automatic run_frame(input int tgt, input bit keep_en, input bit tog,
                           input int hold, input int next_tgt,
                           input int exp_t, input bit exp_s, input int exp_scan);
    int cnt[256];
    int guard;
    int ack0;
    int mthr;
    bit msat;
    for (int b = 0; b < 256; b++) cnt[b] = 0;
    foreach (frame_q[k]) cnt[frame_q[k]]++;
    model_thr(cnt, tgt, mthr, msat);
    exp_thr = mthr;
    exp_sat = msat;
    toggle_mode = tog;
    ack0 = ack_cnt;

    i_target = 24'(tgt);
    i_enable = 1'b1;
    @(negedge i_clk);
    i_enable = keep_en;
    send_frame();

    guard = 0;
    #1;
    while (!o_thr_valid && guard < 2000) begin
      @(negedge i_clk);
      #1;
      guard++;
    end
    check("thr_valid_seen", o_thr_valid, 1'b1);
    check("thr_literal", o_thr, 32'(exp_t));
    check("sat_literal", o_thr_sat, exp_s);
    check("scan_cycles", 32'(scan_cnt), 32'(exp_scan));
    check("pixels_written", 32'(frame_len_seen), 32'(frame_q.size()));
    toggle_mode = 1'b0;

    repeat (hold) @(negedge i_clk);
    @(negedge i_clk);
    i_thr_ready = 1'b1;
    i_target    = 24'(next_tgt);
    @(negedge i_clk);
    i_thr_ready = 1'b0;
    #1;
    exp_fc++;
    check("frame_cnt", o_frame_cnt, 32'(exp_fc));
    check("ack_once", 32'(ack_cnt - ack0), 32'd1);
    check("busy_after_emit", o_busy, keep_en);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held with activity on the pixel inputs: outputs must stay low.
    i_pix_valid = 1'b1;
    i_pix_data  = 8'hAA;
    repeat (3) @(negedge i_clk);
    #1;
    check("rst_pix_ready",  o_pix_ready, 1'b0);
    check("rst_hist_valid", o_hist_valid, 1'b0);
    check("rst_hist_data",  o_hist_data, 8'd0);
    check("rst_hist_ack",   o_hist_ack, 1'b0);
    check("rst_thr_valid",  o_thr_valid, 1'b0);
    check("rst_thr",        o_thr, 8'd0);
    check("rst_thr_sat",    o_thr_sat, 1'b0);
    check("rst_busy",       o_busy, 1'b0);
    check("rst_frame_cnt",  o_frame_cnt, 16'd0);
    i_pix_valid = 1'b0;
    i_pix_data  = '0;
    #2;
    i_reset_n = 1'b1;
    repeat (5) @(negedge i_clk);
    #1;
    check("idle_busy",       o_busy, 1'b0);
    check("idle_thr_valid",  o_thr_valid, 1'b0);
    check("idle_hist_valid", o_hist_valid, 1'b0);
    check("idle_frame_cnt",  o_frame_cnt, 16'd0);

    // Frame A: 3 x 10, 5 x 20, 8 x 200, interleaved.
    frame_q = {8'd10, 8'd200, 8'd20, 8'd200, 8'd10, 8'd20, 8'd200, 8'd200,
               8'd20, 8'd10, 8'd200, 8'd20, 8'd200, 8'd200, 8'd20, 8'd200};
    @(negedge i_clk);
    run_frame(8,  1'b0, 1'b0, 0, 8,  20,  1'b0, 21);   // cum reaches 8 at bin 20
    run_frame(17, 1'b0, 1'b0, 0, 17, 255, 1'b1, 256);  // only 16 pixels: saturate
    run_frame(0,  1'b0, 1'b0, 0, 0,  10,  1'b0, 11);   // zero target -> first nonzero bin
    run_frame(8,  1'b0, 1'b1, 20, 8, 20,  1'b0, 21);   // backpressure + held result

    // Reset in the middle of a saturating scan.
    i_target = 24'd17;
    i_enable = 1'b1;
    @(negedge i_clk);
    i_enable = 1'b0;
    send_frame();
    for (int g = 0; g < 100 && !i_hist_done; g++) @(negedge i_clk);
    check("midscan_done_seen", i_hist_done, 1'b1);
    repeat (50) @(negedge i_clk);
    #3;
    i_reset_n = 1'b0;
    #1;
    check("midscan_rst_busy",      o_busy, 1'b0);
    check("midscan_rst_frame_cnt", o_frame_cnt, 16'd0);
    check("midscan_rst_thr_valid", o_thr_valid, 1'b0);
    check("midscan_rst_thr",       o_thr, 8'd0);
    check("midscan_rst_ack",       o_hist_ack, 1'b0);
    exp_fc = 0;
    repeat (2) @(negedge i_clk);
    #3;
    i_reset_n = 1'b1;
    @(negedge i_clk);

    // Back-to-back: frame A (target 8), then frame B (target 3) entered
    // straight from EMIT with the target re-latched at the handshake.
    run_frame(8, 1'b1, 1'b0, 0, 3, 20, 1'b0, 21);
    frame_q = {8'd50, 8'd7, 8'd50, 8'd255, 8'd50, 8'd7, 8'd50};
    run_frame(3, 1'b0, 1'b0, 0, 3, 50, 1'b0, 51);     // cum 2 at bin 7, 6 at bin 50
    check("b2b_frame_cnt", o_frame_cnt, 16'd2);

    repeat (3) @(negedge i_clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hist_threshold_ctrl.md
HIST_THRESHOLD_CTRL -- requirements
Module: hist_threshold_ctrl

Interface
REQ-001 SHALL have port i_clk, input, 1, single clock; all logic rising-edge.
REQ-002 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have pixel-side ports i_pix_valid (in, 1), i_pix_data (in, 8), i_pix_last (in, 1) and o_pix_ready (out, 1), carrying the upstream frame stream with last marking the final pixel.
REQ-004 SHALL have histogram-write ports o_hist_valid (out, 1), o_hist_data (out, 8), o_hist_last (out, 1) and i_hist_ready (in, 1, the histogram's ready).
REQ-005 SHALL have histogram-read ports i_hist_bins (in, 256x16, bin array), i_hist_done (in, 1, histogram valid) and o_hist_ack (out, 1, histogram ready/release).
REQ-006 SHALL have config ports i_enable (in, 1, run frames) and i_target (in, 24, cumulative pixel count defining threshold).
REQ-007 SHALL have result ports o_thr (out, 8), o_thr_sat (out, 1, target not reached), o_thr_valid (out, 1) and i_thr_ready (in, 1).
REQ-008 SHALL have status ports o_busy (out, 1, state != IDLE) and o_frame_cnt (out, 16, completed frames).

Function
REQ-009 SHALL implement states IDLE, FILL, WAIT_HIST, SCAN, RELEASE, EMIT.
REQ-010 IDLE: i_enable=1 -> FILL next cycle; latch i_target into target register, 0 latched as 1.
REQ-011 FILL: o_hist_valid=i_pix_valid, o_hist_data=i_pix_data, o_hist_last=i_pix_last, o_pix_ready=i_hist_ready, all combinational; zero latency.
REQ-012 Outside FILL: o_pix_ready=0, o_hist_valid=0.
REQ-013 FILL: transfer (i_pix_valid & i_hist_ready) with i_pix_last=1 -> WAIT_HIST.
REQ-014 i_enable deassert during FILL SHALL NOT abort; frame completes.
REQ-015 WAIT_HIST: i_hist_done=1 -> SCAN; clear index to 0 and accumulator to 0.
REQ-016 SCAN: one bin per cycle; sum = acc + i_hist_bins[idx] (24-bit, cannot overflow: 256x65535 < 2^24); acc <= sum.
REQ-017 SCAN: sum >= target -> o_thr <= idx, o_thr_sat <= 0, -> RELEASE; first such idx wins.
REQ-018 SCAN: idx=255 and sum < target -> o_thr <= 255, o_thr_sat <= 1, -> RELEASE.
REQ-019 SCAN latency: idx+1 cycles (max 256); bins SHALL NOT be read after o_hist_ack.
REQ-020 RELEASE: o_hist_ack=1 for exactly one cycle -> EMIT; o_hist_ack=0 in all other states.
REQ-021 EMIT: o_thr_valid=1; o_thr and o_thr_sat stable until i_thr_ready=1.
REQ-022 EMIT handshake: o_frame_cnt increments (wraps 65535->0); -> FILL if i_enable=1 (target re-latched), else IDLE.
REQ-023 i_hist_done outside WAIT_HIST SHALL be ignored (covers residual done the cycle after ack).
REQ-024 FILL after RELEASE SHALL rely on i_hist_ready gating; no pixel is accepted while the histogram clears.

Reset
REQ-025 i_reset_n=0 SHALL force IDLE immediately, independent of i_clk.
REQ-026 Reset SHALL clear o_thr=0, o_thr_sat=0, o_thr_valid=0, o_hist_ack=0, o_frame_cnt=0, target, index and accumulator.
REQ-027 Reset mid-frame or mid-scan SHALL discard the partial result; the histogram is reset by the same reset network.
REQ-028 Combinational outputs SHALL be 0 while in reset (state IDLE).

Structure
REQ-029 startracker_pkg SHALL hold the state enum and constants HIST_BINS=256, BIN_W=16, ACC_W=24, PIX_W=8.
REQ-030 Sub-module hist_cdf_scan (index counter, accumulator, compare) SHALL be the one natural split; the FSM stays in hist_threshold_ctrl.

Verification
REQ-031 Reset-release test: hold i_enable=0 -> all outputs 0, o_busy=0.
REQ-032 Valid threshold, no saturation: 16-pixel frame of values {3x10, 5x20, 8x200}, target=8 -> o_thr=20, o_thr_sat=0, ack pulse once, o_frame_cnt=1.
REQ-033 Saturating target: same frame, target=17 -> o_thr=255, o_thr_sat=1, SCAN lasts 256 cycles.
REQ-034 Zero target: target=0 -> o_thr=10, the first nonzero bin.
REQ-035 Backpressure: i_hist_ready toggled each cycle during FILL and i_thr_ready held low 20 cycles -> no lost pixels, o_thr stable, one ack.
REQ-036 Mid-scan reset and back-to-back frames: assert i_reset_n=0 in SCAN -> IDLE, counter 0; then two frames with i_enable=1 -> o_frame_cnt=2 and the second result is computed from cleared bins.
